// File: rtl/fp_to_int.sv
// IEEE-754 single to signed int32 converter: iterative 1-bit/cycle shifter,
// selectable rounding, NaN/overflow flagging, valid/ready on both sides.
module fp_to_int #(
   parameter int unsigned RSHIFT_CAP = 26,
   parameter logic [31:0] NAN_VALUE  = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [1:0]  round_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] resultCvt,
   output logic        errorCvt,
   output logic        overflowCvt
);

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp_t;

   localparam logic [7:0] CAP8 = 8'(RSHIFT_CAP);

   state_t      state;
   fp_t         op;
   logic [32:0] mag;
   logic        guard;
   logic        sticky;
   logic        shl;
   logic [1:0]  rmode;
   logic [7:0]  cnt;

   // shift plan decoded from the raw operand at accept
   logic [7:0]  a_exp;
   logic [7:0]  rs_amt;
   logic [7:0]  n_shift;
   logic        n_left;

   always_comb begin
      a_exp   = A[30:23];
      rs_amt  = 8'd150 - a_exp;
      n_shift = 8'd0;
      n_left  = 1'b0;
      if (a_exp >= 8'd151 && a_exp <= 8'd157) begin
         n_left  = 1'b1;
         n_shift = a_exp - 8'd150;
      end else if (a_exp >= 8'd1 && a_exp <= 8'd150) begin
         n_shift = (rs_amt > CAP8) ? CAP8 : rs_amt;
      end
   end

   // rounding and result selection, consumed in ROUND
   logic        inc;
   logic [32:0] mag_rnd;
   logic [31:0] mag_neg;
   logic [31:0] sat_val;
   logic        rnd_ovf;
   logic [31:0] fin_res;
   logic        fin_err;
   logic        fin_ovf;

   always_comb begin
      inc = 1'b0;
      case (rmode)
         2'b00:   inc = !op.sign && (guard | sticky);
         2'b01:   inc = op.sign && (guard | sticky);
         2'b10:   inc = guard && (sticky | mag[0]);
         default: inc = guard | sticky;
      endcase
      mag_rnd = mag + {32'd0, inc};
      mag_neg = ~mag_rnd[31:0] + 32'd1;
      rnd_ovf = op.sign ? (mag_rnd > 33'h0_8000_0000) : (mag_rnd > 33'h0_7FFF_FFFF);
      sat_val = op.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;

      fin_res = 32'd0;
      fin_err = 1'b0;
      fin_ovf = 1'b0;
      if (op.exp == 8'd255 && op.frac != 23'd0) begin
         fin_res = NAN_VALUE;
         fin_err = 1'b1;
      end else if (op.exp == 8'd255) begin
         fin_res = sat_val;
         fin_ovf = 1'b1;
      end else if (op.exp >= 8'd158) begin
         // -2^31 is the only representable value at or above this exponent
         if (op.sign && op.exp == 8'd158 && op.frac == 23'd0) begin
            fin_res = 32'h8000_0000;
         end else begin
            fin_res = sat_val;
            fin_ovf = 1'b1;
         end
      end else if (op.exp == 8'd0) begin
         fin_res = 32'd0;
      end else if (rnd_ovf) begin
         fin_res = sat_val;
         fin_ovf = 1'b1;
      end else begin
         fin_res = op.sign ? mag_neg : mag_rnd[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         resultCvt   <= 32'd0;
         errorCvt    <= 1'b0;
         overflowCvt <= 1'b0;
         op          <= '0;
         mag         <= 33'd0;
         guard       <= 1'b0;
         sticky      <= 1'b0;
         shl         <= 1'b0;
         rmode       <= 2'b00;
         cnt         <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op          <= fp_t'(A);
                  mag         <= {9'd0, 1'b1, A[22:0]};
                  guard       <= 1'b0;
                  sticky      <= 1'b0;
                  rmode       <= round_mode;
                  shl         <= n_left;
                  cnt         <= n_shift;
                  errorCvt    <= 1'b0;
                  overflowCvt <= 1'b0;
                  in_ready    <= 1'b0;
                  state       <= (n_shift != 8'd0) ? SHIFT : ROUND;
               end
            end
            SHIFT: begin
               if (shl) begin
                  mag <= mag << 1;
               end else begin
                  // bits past the cap drain through guard into sticky
                  mag    <= mag >> 1;
                  guard  <= mag[0];
                  sticky <= sticky | guard;
               end
               cnt <= cnt - 8'd1;
               if (cnt == 8'd1) state <= ROUND;
            end
            ROUND: begin
               resultCvt   <= fin_res;
               errorCvt    <= fin_err;
               overflowCvt <= fin_ovf;
               out_valid   <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_to_int.sv
// Bench for fp_to_int: directed corner cases plus random operands checked
// against an arithmetic (quotient/remainder) rounding model.
module tb_fp_to_int;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] A = 32'd0;
   logic [1:0]  round_mode = 2'b00;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] resultCvt;
   logic        errorCvt;
   logic        overflowCvt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fp_to_int dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (A),
      .round_mode (round_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .resultCvt  (resultCvt),
      .errorCvt   (errorCvt),
      .overflowCvt(overflowCvt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got %h want %h", tag, got, want);
      end
   endtask

   // value = m * 2^(E-150); round q + rem/2^sh by mode, then range-check as signed
   function automatic void model(input logic [31:0] a, input logic [1:0] md,
                                 output logic [31:0] r, output logic e,
                                 output logic o, output int lat);
      logic   s;
      int     ex, sh, n;
      longint m, q, rem, half, v;
      bit     inexact, up;
      s  = a[31];
      ex = int'(a[30:23]);
      m  = longint'(a[22:0]) + (64'sd1 <<< 23);
      r  = 32'd0;
      e  = 1'b0;
      o  = 1'b0;
      if (ex >= 151 && ex <= 157) n = ex - 150;
      else if (ex >= 1 && ex <= 150) n = (150 - ex > 26) ? 26 : 150 - ex;
      else n = 0;
      lat = n + 2;
      if (ex == 255) begin
         if (a[22:0] != 23'd0) begin
            r = 32'h8000_0000;
            e = 1'b1;
         end else begin
            r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            o = 1'b1;
         end
      end else if (ex == 0) begin
         r = 32'd0;
      end else if (ex > 189) begin
         r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
         o = 1'b1;
      end else begin
         if (ex >= 150) begin
            q = m <<< (ex - 150); rem = 0; half = 1;
         end else if (ex >= 126) begin
            sh   = 150 - ex;
            q    = m >>> sh;
            rem  = m - (q <<< sh);
            half = 64'sd1 <<< (sh - 1);
         end else begin
            q = 0; rem = 1; half = 2;
         end
         inexact = (rem != 0);
         case (md)
            2'b00:   up = !s && inexact;
            2'b01:   up = s && inexact;
            2'b10:   up = (rem > half) || (rem == half && q[0]);
            default: up = inexact;
         endcase
         if (up) q = q + 1;
         v = s ? -q : q;
         if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
            r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            o = 1'b1;
         end else begin
            r = v[31:0];
         end
      end
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [1:0] md,
                         input logic [31:0] er, input logic ee, input logic eo,
                         input int hold);
      logic [31:0] mr;
      logic        me, mo;
      int          elat, lat;
      bit          seen, stable;
      model(a, md, mr, me, mo, elat);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      @(negedge clk);
      A = a; round_mode = md; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; A = $urandom; round_mode = 2'($urandom);
      lat  = 1;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk);
         #1 lat++;
         if (out_valid) seen = 1'b1;
      end
      chk("out_valid_timeout", 32'(seen), 32'd1);
      chk($sformatf("latency_%h", a), 32'(lat), 32'(elat));
      chk($sformatf("result_%h_m%0d", a, md), resultCvt, er);
      chk($sformatf("error_%h", a), 32'(errorCvt), 32'(ee));
      chk($sformatf("overflow_%h", a), 32'(overflowCvt), 32'(eo));
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'($urandom); A = $urandom;
         @(posedge clk);
         #1;
         if (!out_valid || in_ready || resultCvt !== er || errorCvt !== ee || overflowCvt !== eo)
            stable = 1'b0;
      end
      if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("in_ready_after_done", 32'(in_ready), 32'd1);
      chk("out_valid_drop", 32'(out_valid), 32'd0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [1:0]  md;
      logic [31:0] r;
      logic        e;
      logic        o;
      int          hold;
   } vec_t;

   vec_t dir[$] = '{
      '{32'h40490FDB, 2'b10, 32'h0000_0003, 1'b0, 1'b0, 5},
      '{32'hC0200000, 2'b10, 32'hFFFF_FFFE, 1'b0, 1'b0, 0},
      '{32'hC0200000, 2'b11, 32'hFFFF_FFFD, 1'b0, 1'b0, 0},
      '{32'hC0200000, 2'b00, 32'hFFFF_FFFE, 1'b0, 1'b0, 0},
      '{32'hC0200000, 2'b01, 32'hFFFF_FFFD, 1'b0, 1'b0, 0},
      '{32'h3F000000, 2'b10, 32'h0000_0000, 1'b0, 1'b0, 0},
      '{32'h3F000000, 2'b00, 32'h0000_0001, 1'b0, 1'b0, 0},
      '{32'h00000001, 2'b01, 32'h0000_0000, 1'b0, 1'b0, 0},
      '{32'h00000001, 2'b11, 32'h0000_0000, 1'b0, 1'b0, 0},
      '{32'h80000000, 2'b01, 32'h0000_0000, 1'b0, 1'b0, 0},
      '{32'hBF000000, 2'b00, 32'h0000_0000, 1'b0, 1'b0, 0},
      '{32'h40200000, 2'b10, 32'h0000_0002, 1'b0, 1'b0, 0},
      '{32'h3FC00000, 2'b10, 32'h0000_0002, 1'b0, 1'b0, 0},
      '{32'h3E800000, 2'b11, 32'h0000_0001, 1'b0, 1'b0, 0},
      '{32'h33000000, 2'b00, 32'h0000_0001, 1'b0, 1'b0, 0},
      '{32'h33000000, 2'b10, 32'h0000_0000, 1'b0, 1'b0, 0},
      '{32'h4B7FFFFF, 2'b10, 32'h00FF_FFFF, 1'b0, 1'b0, 0},
      '{32'h4EFFFFFF, 2'b00, 32'h7FFF_FF80, 1'b0, 1'b0, 0},
      '{32'h4F000000, 2'b10, 32'h7FFF_FFFF, 1'b0, 1'b1, 0},
      '{32'hCF000000, 2'b00, 32'h8000_0000, 1'b0, 1'b0, 0},
      '{32'hCF000001, 2'b00, 32'h8000_0000, 1'b0, 1'b1, 0},
      '{32'h7FC00000, 2'b10, 32'h8000_0000, 1'b1, 1'b0, 0},
      '{32'hFF800000, 2'b10, 32'h8000_0000, 1'b0, 1'b1, 0}
   };

   initial begin
      logic [31:0] ra, mr;
      logic        me, mo;
      int          ml, sel, ex;
      bit          leak;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", resultCvt, 32'd0);
      chk("rst_flags", {30'd0, errorCvt, overflowCvt}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      foreach (dir[i]) run_op(dir[i].a, dir[i].md, dir[i].r, dir[i].e, dir[i].o, dir[i].hold);

      // reset in the middle of a long right shift
      @(negedge clk);
      A = 32'h40490FDB; round_mode = 2'b10; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_result", resultCvt, 32'd0);
      chk("midrst_flags", {30'd0, errorCvt, overflowCvt}, 32'd0);
      leak = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1 if (out_valid) leak = 1'b1;
      end
      chk("midrst_no_output", 32'(leak), 32'd0);
      run_op(32'h3F800000, 2'($urandom), 32'd1, 1'b0, 1'b0, 0);

      for (int t = 0; t < 300; t++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       ex = 0;
            1:       ex = 255;
            2:       ex = int'($urandom_range(158, 200));
            3:       ex = int'($urandom_range(1, 125));
            default: ex = int'($urandom_range(120, 157));
         endcase
         ra = $urandom;
         ra[30:23] = 8'(ex);
         if ($urandom_range(0, 5) == 0) ra[22:0] = 23'd0;
         else if ($urandom_range(0, 5) == 0) ra[21:0] = {1'b1, 21'd0};
         model(ra, 2'(t), mr, me, mo, ml);
         run_op(ra, 2'(t), mr, me, mo, int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
